// File: rtl/mac_psum_accumulator.sv
// Accumulates NUM_MACS signed partial sums per beat across a dot product, then rounds,
// shifts and saturates the total into a single registered valid/ready result.
// Optional clipping of the result is enabled by defining MAC_ACC_SAT_EN.
module mac_psum_accumulator #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_MACS    = 2,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                psum_valid,
  output logic                                psum_ready,
  input  logic [NUM_MACS-1:0][2*WIDTH-1:0]    psum,
  input  logic                                psum_last,
  input  logic [SHIFT_WIDTH-1:0]              shift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUT_WIDTH-1:0]                out_data,
  output logic                                out_sat,
  output logic [15:0]                         out_beats,
  output logic                                busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned RW = ACC_WIDTH + 1;
  localparam int unsigned CW = 16;

  localparam logic signed [RW-1:0] MAX_V = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_sat_q, out_sat_d;
  logic [CW-1:0]          out_beats_q, out_beats_d;

  logic [ACC_WIDTH-1:0]   beat_sum;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [SHIFT_WIDTH-1:0] shift_eff;
  logic signed [RW-1:0]   acc_ext;
  logic signed [RW-1:0]   rnd_add;
  logic signed [RW-1:0]   rounded;
  logic [OUT_WIDTH-1:0]   res_data;
  logic                   res_sat;
  logic [CW-1:0]          cnt_inc;
  logic [CW-1:0]          final_cnt;
  logic                   accept;

  assign psum_ready = !out_valid_q || out_ready;
  assign accept     = psum_valid && psum_ready;

  // Sign-extend every tree's partial sum and reduce them into one beat total.
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < NUM_MACS; i++) begin
      beat_sum = beat_sum + {{(ACC_WIDTH-PW){psum[i][PW-1]}}, psum[i]};
    end
  end

  // The accumulator is empty in IDLE, so the first beat starts from zero.
  assign acc_next  = ((state_q == ACC) ? acc_q : '0) + beat_sum;
  assign shift_eff = (state_q == IDLE) ? shift : shift_q;

  // Round half up, computed one bit wider than the accumulator so the bias cannot wrap.
  always_comb begin
    acc_ext = {acc_next[ACC_WIDTH-1], acc_next};
    rnd_add = '0;
    rounded = acc_ext;
    if (shift_eff != '0) begin
      rnd_add = RW'(1) << (shift_eff - SHIFT_WIDTH'(1));
      rounded = (acc_ext + rnd_add) >>> shift_eff;
    end
  end

`ifdef MAC_ACC_SAT_EN
  always_comb begin
    res_sat  = 1'b0;
    res_data = rounded[OUT_WIDTH-1:0];
    if (rounded > MAX_V) begin
      res_sat  = 1'b1;
      res_data = MAX_V[OUT_WIDTH-1:0];
    end else if (rounded < MIN_V) begin
      res_sat  = 1'b1;
      res_data = MIN_V[OUT_WIDTH-1:0];
    end
  end
`else
  logic unused_round_hi;
  assign unused_round_hi = ^{rounded[RW-1:OUT_WIDTH], MAX_V, MIN_V};
  assign res_data        = rounded[OUT_WIDTH-1:0];
  assign res_sat         = 1'b0;
`endif

  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign final_cnt = (state_q == IDLE) ? CW'(1) : cnt_inc;

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_beats_d = out_beats_q;
    if (accept) begin
      if (state_q == IDLE) begin
        shift_d = shift;
      end
      if (psum_last) begin
        state_d     = IDLE;
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = res_data;
        out_sat_d   = res_sat;
        out_beats_d = final_cnt;
      end else begin
        state_d = ACC;
        acc_d   = acc_next;
        cnt_d   = final_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_beats = out_beats_q;
  assign busy      = (state_q == ACC);

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// Directed bench for mac_psum_accumulator: a dot-product model checked every cycle
// plus hand-computed literal results.
module tb_mac_psum_accumulator;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [N-1:0][31:0] psum = '0;
  logic              psum_last = 1'b0;
  logic [4:0]        shift = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [15:0]       out_data;
  logic              out_sat;
  logic [15:0]       out_beats;
  logic              busy;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  // Model state: the running dot product and the expected output register.
  bit          m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  bit          m_sat   = 1'b0;
  int          m_beats = 0;
  longint      m_sum   = 0;
  int          m_cnt   = 0;
  bit          m_in_dp = 1'b0;
  int          m_shift = 0;
  bit          m_rdy;

  mac_psum_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .psum_valid (psum_valid),
    .psum_ready (psum_ready),
    .psum       (psum),
    .psum_last  (psum_last),
    .shift      (shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .out_beats  (out_beats),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_result(input longint x, input int s,
                                       output logic [15:0] d, output bit sat);
    longint r;
    r = (s == 0) ? x : ((x + (longint'(1) <<< (s - 1))) >>> s);
`ifdef MAC_ACC_SAT_EN
    if (r > 32767) begin
      d = 16'h7fff; sat = 1'b1;
    end else if (r < -32768) begin
      d = 16'h8000; sat = 1'b1;
    end else begin
      d = 16'(r); sat = 1'b0;
    end
`else
    d = 16'(r);
    sat = 1'b0;
`endif
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_valid = 1'b0; m_data = '0; m_sat = 1'b0; m_beats = 0;
      m_sum = 0; m_cnt = 0; m_in_dp = 1'b0;
    end else begin
      m_rdy = !m_valid || out_ready;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (psum_valid && m_rdy) begin
        if (!m_in_dp) begin
          m_shift = int'(shift); m_sum = 0; m_cnt = 0;
        end
        for (int i = 0; i < N; i++) m_sum += longint'($signed(psum[i]));
        m_sum = (m_sum <<< 24) >>> 24;
        if (m_cnt < 65535) m_cnt++;
        if (psum_last) begin
          model_result(m_sum, m_shift, m_data, m_sat);
          m_beats = m_cnt;
          m_valid = 1'b1;
          m_in_dp = 1'b0;
        end else begin
          m_in_dp = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst && run_cmp) begin
      chk("cmp_valid", longint'(out_valid), longint'(m_valid));
      chk("cmp_ready", longint'(psum_ready), longint'(!m_valid || out_ready));
      chk("cmp_busy", longint'(busy), longint'(m_in_dp));
      if (m_valid) begin
        chk("cmp_data", longint'(out_data), longint'(m_data));
        chk("cmp_sat", longint'(out_sat), longint'(m_sat));
        chk("cmp_beats", longint'(out_beats), longint'(m_beats));
      end
    end
  end

  task automatic drive(input bit v, input bit l, input int a, input int b, input int sh);
    @(posedge clk);
    #1;
    psum_valid = v;
    psum_last  = l;
    psum[0]    = 32'(a);
    psum[1]    = 32'(b);
    shift      = 5'(sh);
  endtask

  task automatic result(input string name, input int d, input int beats, input int sat);
    drive(1'b0, 1'b0, 0, 0, 0);
    @(negedge clk);
    chk({name, "_valid"}, longint'(out_valid), 1);
    chk({name, "_data"}, longint'($signed(out_data)), longint'(d));
    chk({name, "_beats"}, longint'(out_beats), longint'(beats));
    chk({name, "_sat"}, longint'(out_sat), longint'(sat));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_sat", longint'(out_sat), 0);
    chk("rst_beats", longint'(out_beats), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ready", longint'(psum_ready), 1);
    rst = 1'b1;
    run_cmp = 1'b1;

    drive(1, 1, 100, 200, 0);
    result("single", 300, 1, 0);

    drive(1, 0, 1, 2, 0);
    drive(1, 0, 3, 4, 0);
    @(negedge clk);
    chk("three_busy2", longint'(busy), 1);
    drive(1, 1, 5, 6, 0);
    @(negedge clk);
    chk("three_busy3", longint'(busy), 1);
    result("three", 21, 3, 0);

    drive(1, 1, 3, 2, 1);
    result("rnd_pos", 3, 1, 0);
    drive(1, 1, -3, -2, 1);
    result("rnd_neg", -2, 1, 0);
    drive(1, 1, 7, 0, 2);
    result("rnd_s2", 2, 1, 0);

`ifdef MAC_ACC_SAT_EN
    drive(1, 1, 20000, 20000, 0);
    result("sat_hi", 32767, 1, 1);
    drive(1, 1, -20000, -20000, 0);
    result("sat_lo", -32768, 1, 1);
`else
    drive(1, 1, 20000, 20000, 0);
    result("wrap_hi", -25536, 1, 0);
    drive(1, 1, -20000, -20000, 0);
    result("wrap_lo", 25536, 1, 0);
`endif

    // Shift presented after the first beat must be ignored.
    drive(1, 0, 8, 8, 2);
    drive(1, 1, 8, 0, 0);
    result("shift_hold", 6, 2, 0);

    // Back-to-back single-beat dot products.
    drive(1, 1, 1000, -1, 0);
    drive(1, 1, -7, 0, 1);
    drive(1, 1, 12345, 6789, 3);
    @(negedge clk);
    chk("b2b_data", longint'($signed(out_data)), -3);
    drive(1, 1, -1, 0, 31);
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Backpressure: result held, beats refused, then release and reload together.
    drive(1, 1, 10, 20, 0);
    out_ready = 1'b0;
    drive(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", longint'(psum_ready), 0);
      chk("bp_hold", longint'($signed(out_data)), 30);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    result("bp_reload", 2, 1, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a dot product.
    drive(1, 0, 5, 5, 0);
    drive(1, 0, 5, 5, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_busy", longint'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_data", longint'(out_data), 0);
    chk("mid_rst_sat", longint'(out_sat), 0);
    chk("mid_rst_beats", longint'(out_beats), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, 0, 0);
    result("post_rst", 1, 1, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
